poly_evaluator: RTL and testbench

Registered polynomial evaluator: computes sum = Σ coeff_i · x^i for i = 0..10, with 16-bit signed coefficients and argument and a 32-bit wrap-around result. It is the arithmetic core of the polynomial-evaluator accelerator. The surrounding controller latches a coefficient vector and an argument, then captures `sum` into its result FIFO. The block has no memory of coefficient sets; the controller owns storage and sequencing.

---
 rtl/poly_evaluator_pkg.sv | 17 +
 rtl/poly_evaluator_if.sv | 25 ++
 rtl/poly_evaluator_horner_stage.sv | 14 +
 rtl/poly_evaluator.sv | 67 ++++++
 tb/tb_poly_evaluator.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/poly_evaluator_pkg.sv
// Shared types and sizes for the polynomial evaluator: widths, degree and
// the sign-extension helper used at the datapath inputs.
package poly_pkg;

  localparam int POLY_N   = 10;
  localparam int COEFF_W  = 16;
  localparam int RESULT_W = 32;

  typedef logic signed [COEFF_W-1:0]  coeff_t;
  typedef logic signed [RESULT_W-1:0] result_t;

  // A size cast of a signed operand replicates the sign bit.
  function automatic result_t sext(input coeff_t v);
    return result_t'(v);
  endfunction

endpackage

// File: rtl/poly_evaluator_if.sv
// Operand/result bundle between the accelerator controller (master) and the
// evaluator core (slave).
interface poly_evaluator_if;
  import poly_pkg::*;

  coeff_t  x;
  coeff_t  coeff0, coeff1, coeff2, coeff3, coeff4, coeff5;
  coeff_t  coeff6, coeff7, coeff8, coeff9, coeff10;
  logic    in_valid;
  result_t sum;
  logic    out_valid;

  modport master (
    output x, coeff0, coeff1, coeff2, coeff3, coeff4, coeff5,
           coeff6, coeff7, coeff8, coeff9, coeff10, in_valid,
    input  sum, out_valid
  );

  modport slave (
    input  x, coeff0, coeff1, coeff2, coeff3, coeff4, coeff5,
           coeff6, coeff7, coeff8, coeff9, coeff10, in_valid,
    output sum, out_valid
  );

endinterface

// File: rtl/poly_evaluator_horner_stage.sv
// One Horner step: acc_out = acc_in * x + c, all arithmetic modulo 2^32.
module horner_stage
  import poly_pkg::*;
(
  input  result_t acc_in,
  input  result_t x,
  input  result_t c,
  output result_t acc_out
);

  // Low 32 bits of the product are identical for signed and unsigned operands.
  assign acc_out = acc_in * x + c;

endmodule

// File: rtl/poly_evaluator.sv
// Polynomial evaluator core: sign-extends the operands, evaluates a chain of
// ten Horner stages combinationally and registers the result with 1-cycle latency.
module poly_evaluator
  import poly_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  poly_evaluator_if.slave bus
);

  result_t c_ext [POLY_N+1];
  result_t acc   [POLY_N+1];
  result_t x_ext;

  result_t sum_d, sum_q;
  logic    out_valid_d, out_valid_q;

  assign x_ext      = sext(bus.x);
  assign c_ext[0]   = sext(bus.coeff0);
  assign c_ext[1]   = sext(bus.coeff1);
  assign c_ext[2]   = sext(bus.coeff2);
  assign c_ext[3]   = sext(bus.coeff3);
  assign c_ext[4]   = sext(bus.coeff4);
  assign c_ext[5]   = sext(bus.coeff5);
  assign c_ext[6]   = sext(bus.coeff6);
  assign c_ext[7]   = sext(bus.coeff7);
  assign c_ext[8]   = sext(bus.coeff8);
  assign c_ext[9]   = sext(bus.coeff9);
  assign c_ext[10]  = sext(bus.coeff10);

  // Chain runs from the top coefficient down: acc[i] = acc[i+1]*x + c_i.
  assign acc[POLY_N] = c_ext[POLY_N];

  for (genvar i = 0; i < POLY_N; i++) begin : g_stage
    horner_stage u_stage (
      .acc_in (acc[i+1]),
      .x      (x_ext),
      .c      (c_ext[i]),
      .acc_out(acc[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d       = acc[0];
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_poly_evaluator.sv
// Directed bench for poly_evaluator: expected sums come from a power-series
// model, are queued when an evaluation is launched and popped when it lands.
module tb_poly_evaluator;
  import poly_pkg::*;

  logic clk;
  logic reset;

  poly_evaluator_if bus ();

  poly_evaluator dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] tb_x;
  logic [15:0] tb_c [11];
  logic [31:0] exp_q [$];
  logic [31:0] held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: sum of c_i * x^i with running powers, all kept to 32 bits.
  function automatic logic [31:0] model();
    logic [31:0] p;
    logic [31:0] acc;
    logic [31:0] xs;
    p   = 32'd1;
    acc = 32'd0;
    xs  = {{16{tb_x[15]}}, tb_x};
    for (int i = 0; i <= 10; i++) begin
      acc = acc + {{16{tb_c[i][15]}}, tb_c[i]} * p;
      p   = p * xs;
    end
    return acc;
  endfunction

  task automatic clear_coeffs();
    for (int i = 0; i <= 10; i++) tb_c[i] = 16'd0;
  endtask

  task automatic randomize_inputs();
    tb_x = 16'($urandom);
    for (int i = 0; i <= 10; i++) tb_c[i] = 16'($urandom);
  endtask

  task automatic drive(input logic v);
    bus.x        = tb_x;
    bus.coeff0   = tb_c[0];
    bus.coeff1   = tb_c[1];
    bus.coeff2   = tb_c[2];
    bus.coeff3   = tb_c[3];
    bus.coeff4   = tb_c[4];
    bus.coeff5   = tb_c[5];
    bus.coeff6   = tb_c[6];
    bus.coeff7   = tb_c[7];
    bus.coeff8   = tb_c[8];
    bus.coeff9   = tb_c[9];
    bus.coeff10  = tb_c[10];
    bus.in_valid = v;
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic step(input logic v, input string tag);
    logic [31:0] e;
    @(negedge clk);
    drive(v);
    if (v) exp_q.push_back(model());
    @(posedge clk);
    #1;
    if (v) begin
      check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_sum"}, bus.sum, e);
        held = e;
      end
    end else begin
      check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_hold"}, bus.sum, held);
    end
  endtask

  initial begin
    reset = 1'b0;
    held  = 32'd0;
    randomize_inputs();
    drive(1'b1);

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_async_sum", bus.sum, 32'd0);
    check("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      randomize_inputs();
      drive(1'b1);
      @(posedge clk);
      #1;
      check("rst_hold_sum", bus.sum, 32'd0);
      check("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0);
    step(1'b0, "post_rst_idle");

    clear_coeffs();
    tb_c[0] = 16'd1; tb_c[1] = 16'd2; tb_c[2] = 16'd3; tb_x = 16'd2;
    step(1'b1, "basic");
    check("basic_const", held, 32'd17);

    for (int i = 0; i <= 10; i++) tb_c[i] = 16'd1;
    tb_x = 16'hFFFF;
    step(1'b1, "all_ones_xm1");
    check("all_ones_const", held, 32'd1);

    clear_coeffs();
    tb_c[0] = 16'hFFFB; tb_x = 16'd1234;
    step(1'b1, "neg_c0");
    check("neg_c0_const", held, 32'hFFFF_FFFB);

    clear_coeffs();
    tb_c[10] = 16'd1; tb_c[0] = 16'd3; tb_x = 16'd16;
    step(1'b1, "wrap_x16");
    check("wrap_x16_const", held, 32'd3);

    clear_coeffs();
    tb_c[1] = 16'h7FFF; tb_x = 16'h7FFF;
    step(1'b1, "wrap_max");
    check("wrap_max_const", held, 32'h3FFF_0001);

    // Back-to-back evaluations, then idle with changing inputs.
    clear_coeffs();
    tb_c[1] = 16'd1;
    for (int k = 0; k < 4; k++) begin
      tb_x = 16'(k);
      step(1'b1, "stream");
      check("stream_const", held, 32'(k));
    end
    randomize_inputs();
    step(1'b0, "stream_drop");
    randomize_inputs();
    step(1'b0, "stream_drop2");

    // Reset while an evaluation is pending.
    clear_coeffs();
    tb_c[1] = 16'd1; tb_x = 16'd5;
    step(1'b1, "midrst_pre");
    @(negedge clk);
    tb_x = 16'd6;
    drive(1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_async_sum", bus.sum, 32'd0);
    check("midrst_async_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_win_sum", bus.sum, 32'd0);
    check("midrst_win_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0);
    exp_q.delete();
    held = 32'd0;
    step(1'b0, "midrst_idle1");
    step(1'b0, "midrst_idle2");

    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      step(1'b1, "random");
    end
    step(1'b0, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
